proc_rst_ctrl: RTL and testbench

Run-control stage that sits directly upstream of the processor in the simulation hierarchy and also consumes the processor's status.
- Turns the raw board reset into a synchronised, stretched core reset for proc.
- Counts executed cycles and watches proc's err and halt outputs.
- Freezes the run on error, halt or watchdog expiry, and reports a final status code to the bench.

---
 rtl/proc_ctrl_pkg.sv | 22 ++
 rtl/rst_sync.sv | 25 ++
 rtl/proc_rst_ctrl.sv | 87 ++++++++
 tb/tb_proc_rst_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/proc_ctrl_pkg.sv
// Shared run-control types: FSM states, status codes reported to the bench, default parameters.
package proc_ctrl_pkg;

   typedef enum logic [2:0] {
      RESET_HOLD,
      RUN,
      HALTED,
      ERROR,
      TIMEOUT
   } state_t;

   localparam logic [1:0] ST_RUN     = 2'd0;
   localparam logic [1:0] ST_HALT    = 2'd1;
   localparam logic [1:0] ST_ERR     = 2'd2;
   localparam logic [1:0] ST_TIMEOUT = 2'd3;

   localparam int SYNC_STAGES_DEF = 2;
   localparam int HOLD_CYCLES_DEF = 8;
   localparam int WDOG_CYCLES_DEF = 100000;
   localparam int CNT_W_DEF       = 32;

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset chain; sync_o rises SYNC_STAGES edges after rst releases.
// No flow control: a constant 1 shifts in, any low pulse on rst clears the whole chain.
module rst_sync
   import proc_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic rst,
   output logic sync_o
);

   logic [SYNC_STAGES-1:0] chain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         chain <= '0;
      end else begin
         chain <= {chain[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_o = chain[SYNC_STAGES-1];

endmodule

// File: rtl/proc_rst_ctrl.sv
// Run control for proc: stretched core reset, RUN-cycle counter, freeze on err/halt/watchdog.
// All outputs registered; err_i/halt_i reach done_o one edge after they are sampled.
module proc_rst_ctrl
   import proc_ctrl_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int WDOG_CYCLES = WDOG_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             err_i,
   input  logic             halt_i,
   output logic             core_rst_o,
   output logic             stall_o,
   output logic [CNT_W-1:0] cycle_cnt_o,
   output logic             done_o,
   output logic [1:0]       status_o
);

   localparam logic [7:0]       HOLD_LAST = 8'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WDOG_LIM  = CNT_W'(WDOG_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state;
   logic [7:0]       hold_cnt;
   logic             sync_rel;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wdog_hit;

   rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
      .clk    (clk),
      .rst    (rst),
      .sync_o (sync_rel)
   );

   // Saturating increment; the watchdog compares against the post-increment value.
   assign cnt_nxt  = (cycle_cnt_o == CNT_MAX) ? cycle_cnt_o : cycle_cnt_o + CNT_W'(1);
   assign wdog_hit = (WDOG_CYCLES != 0) && (cnt_nxt == WDOG_LIM);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RESET_HOLD;
         hold_cnt    <= '0;
         core_rst_o  <= 1'b1;
         stall_o     <= 1'b0;
         cycle_cnt_o <= '0;
         done_o      <= 1'b0;
         status_o    <= ST_RUN;
      end else begin
         case (state)
            RESET_HOLD: begin
               if (sync_rel) begin
                  if (hold_cnt == HOLD_LAST) begin
                     state      <= RUN;
                     core_rst_o <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt + 8'd1;
                  end
               end
            end
            RUN: begin
               cycle_cnt_o <= cnt_nxt;
               if (err_i || halt_i || wdog_hit) begin
                  stall_o <= 1'b1;
                  done_o  <= 1'b1;
               end
               if (err_i) begin
                  state    <= ERROR;
                  status_o <= ST_ERR;
               end else if (halt_i) begin
                  state    <= HALTED;
                  status_o <= ST_HALT;
               end else if (wdog_hit) begin
                  state    <= TIMEOUT;
                  status_o <= ST_TIMEOUT;
               end
            end
            default: begin
               // Terminal states hold everything until rst drops.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_rst_ctrl.sv
// Bench for proc_rst_ctrl: four parameterisations share stimulus and are checked every cycle
// against an edge-counting model, plus literal expectations at the interesting points.
module tb_proc_rst_ctrl;

   localparam int     N       = 4;
   localparam int     LIM [N] = '{10, 10, 10, 4};
   localparam int     WD  [N] = '{100000, 16, 0, 0};
   localparam longint MX  [N] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};

   logic        clk  = 1'b0;
   logic        rst  = 1'b1;
   logic        err  = 1'b0;
   logic        halt = 1'b0;
   logic        crst [N];
   logic        stl  [N];
   logic        dn   [N];
   logic [1:0]  sts  [N];
   logic [31:0] cnt  [3];
   logic [3:0]  cnt_d;

   int     errors = 0;
   int     checks = 0;
   int     rel  [N];
   int     mst  [N];
   longint mcnt [N];

   always #5 clk = ~clk;

   proc_rst_ctrl u_a (
      .clk(clk), .rst(rst), .err_i(err), .halt_i(halt),
      .core_rst_o(crst[0]), .stall_o(stl[0]), .cycle_cnt_o(cnt[0]),
      .done_o(dn[0]), .status_o(sts[0])
   );

   proc_rst_ctrl #(.WDOG_CYCLES(16)) u_b (
      .clk(clk), .rst(rst), .err_i(err), .halt_i(halt),
      .core_rst_o(crst[1]), .stall_o(stl[1]), .cycle_cnt_o(cnt[1]),
      .done_o(dn[1]), .status_o(sts[1])
   );

   proc_rst_ctrl #(.WDOG_CYCLES(0)) u_c (
      .clk(clk), .rst(rst), .err_i(err), .halt_i(halt),
      .core_rst_o(crst[2]), .stall_o(stl[2]), .cycle_cnt_o(cnt[2]),
      .done_o(dn[2]), .status_o(sts[2])
   );

   proc_rst_ctrl #(.SYNC_STAGES(3), .HOLD_CYCLES(1), .WDOG_CYCLES(0), .CNT_W(4)) u_d (
      .clk(clk), .rst(rst), .err_i(err), .halt_i(halt),
      .core_rst_o(crst[3]), .stall_o(stl[3]), .cycle_cnt_o(cnt_d),
      .done_o(dn[3]), .status_o(sts[3])
   );

   // Model: count edges since release; once LIM edges are seen the core runs,
   // each further edge is one RUN cycle until an event freezes the status.
   always @(posedge clk or negedge rst) begin
      for (int i = 0; i < N; i++) begin
         if (!rst) begin
            rel[i]  = 0;
            mst[i]  = 0;
            mcnt[i] = 0;
         end else if (mst[i] == 0) begin
            if (rel[i] < LIM[i]) begin
               rel[i]++;
            end else begin
               if (mcnt[i] < MX[i]) mcnt[i]++;
               if (err)                                    mst[i] = 2;
               else if (halt)                              mst[i] = 1;
               else if (WD[i] != 0 && mcnt[i] == WD[i])    mst[i] = 3;
            end
         end
      end
   end

   function automatic longint cnt_of(input int i);
      return (i == 3) ? longint'(cnt_d) : longint'(cnt[i % 3]);
   endfunction

   task automatic chk(input string nm, input int i, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] at %0t: got %0d expected %0d", nm, i, $time, act, exp);
      end
   endtask

   task automatic chk_lit(input string tag, input int i, input int c, input int s,
                          input int d, input int st, input longint n);
      chk({tag, ".core_rst"}, i, longint'(crst[i]), c);
      chk({tag, ".stall"},    i, longint'(stl[i]),  s);
      chk({tag, ".done"},     i, longint'(dn[i]),   d);
      chk({tag, ".status"},   i, longint'(sts[i]),  st);
      chk({tag, ".cnt"},      i, cnt_of(i),         n);
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         chk("m.core_rst", i, longint'(crst[i]), (rel[i] < LIM[i]) ? 1 : 0);
         chk("m.stall",    i, longint'(stl[i]),  (mst[i] != 0) ? 1 : 0);
         chk("m.done",     i, longint'(dn[i]),   (mst[i] != 0) ? 1 : 0);
         chk("m.status",   i, longint'(sts[i]),  mst[i]);
         chk("m.cnt",      i, cnt_of(i),         mcnt[i]);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #1 rst = 1'b0;
      tick(3);
      chk_lit("rst", 0, 1, 0, 0, 0, 0);

      // Bring-up and halt on the 5th RUN cycle.
      rst = 1'b1;
      tick(9);
      chk_lit("e9", 0, 1, 0, 0, 0, 0);
      chk_lit("e9", 3, 0, 0, 0, 0, 5);
      tick(1);
      chk_lit("e10", 0, 0, 0, 0, 0, 0);
      tick(4);
      halt = 1'b1;
      tick(1);
      halt = 1'b0;
      chk_lit("halt", 0, 0, 1, 1, 1, 5);
      chk_lit("halt", 3, 0, 1, 1, 1, 11);
      tick(20);
      chk_lit("halt+20", 0, 0, 1, 1, 1, 5);

      // err and halt together on RUN cycle 3.
      rst = 1'b0;
      #1;
      chk_lit("async0", 0, 1, 0, 0, 0, 0);
      tick(1);
      rst = 1'b1;
      tick(12);
      err  = 1'b1;
      halt = 1'b1;
      tick(1);
      err  = 1'b0;
      halt = 1'b0;
      chk_lit("both", 0, 0, 1, 1, 2, 3);

      // Events during hold are ignored; then watchdog and free-running checks.
      rst = 1'b0;
      tick(1);
      rst  = 1'b1;
      err  = 1'b1;
      halt = 1'b1;
      tick(8);
      err  = 1'b0;
      halt = 1'b0;
      tick(2);
      chk_lit("hold", 0, 0, 0, 0, 0, 0);
      chk_lit("hold", 3, 0, 1, 1, 2, 1);
      tick(15);
      chk_lit("wd15", 1, 0, 0, 0, 0, 15);
      tick(1);
      chk_lit("wd16", 1, 0, 1, 1, 3, 16);
      chk_lit("wd16", 0, 0, 0, 0, 0, 16);
      tick(984);
      chk_lit("run1000", 2, 0, 0, 0, 0, 1000);
      chk_lit("run1000", 0, 0, 0, 0, 0, 1000);

      // Reset mid-run with a sub-cycle glitch, then mid-terminal.
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(17);
      chk_lit("run7", 0, 0, 0, 0, 0, 7);
      #2 rst = 1'b0;
      #1;
      chk_lit("glitch", 0, 1, 0, 0, 0, 0);
      #2 rst = 1'b1;
      tick(9);
      chk_lit("re9", 0, 1, 0, 0, 0, 0);
      tick(1);
      chk_lit("re10", 0, 0, 0, 0, 0, 0);
      err = 1'b1;
      tick(1);
      err = 1'b0;
      chk_lit("err1", 0, 0, 1, 1, 2, 1);
      tick(3);
      #2 rst = 1'b0;
      #1;
      chk_lit("term_rst", 0, 1, 0, 0, 0, 0);
      tick(1);
      rst = 1'b1;
      tick(9);
      chk_lit("tr9", 0, 1, 0, 0, 0, 0);
      tick(1);
      chk_lit("tr10", 0, 0, 0, 0, 0, 0);

      // Narrow counter saturates at all-ones.
      tick(30);
      chk_lit("sat", 3, 0, 0, 0, 0, 15);
      chk_lit("sat", 0, 0, 0, 0, 0, 30);
      chk_lit("sat", 1, 0, 1, 1, 3, 16);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
